// File: rtl/smoke_mc_bfm_if.sv
// rtl/smoke_mc_bfm_if.sv - request and merged-output handshake bundle for smoke_mc_bfm
interface smoke_mc_bfm_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        req_valid;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH-1:0]        req_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/smoke_mc_bfm.sv
// rtl/smoke_mc_bfm.sv - per-channel FIFOs merged round-robin onto one registered output stage
// Carries per-channel and total accepted-transfer counters.
module smoke_mc_bfm #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  smoke_mc_bfm_if.slave           bus,
  output logic [N_CH*CNT_W-1:0]   ch_count_o,
  output logic [31:0]             txn_count_o,
  output logic                    idle_o
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [N_CH][DEPTH];
  logic [PW-1:0]     wr_ptr_q [N_CH];
  logic [PW-1:0]     wr_ptr_d [N_CH];
  logic [PW-1:0]     rd_ptr_q [N_CH];
  logic [PW-1:0]     rd_ptr_d [N_CH];
  logic [CNT_W-1:0]  ch_cnt_q [N_CH];
  logic [CNT_W-1:0]  ch_cnt_d [N_CH];

  logic [N_CH-1:0]   full;
  logic [N_CH-1:0]   empty;
  logic [N_CH-1:0]   push;
  logic [N_CH-1:0]   pop;

  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_found;
  int                best_dist;

  logic              out_valid;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [31:0]       txn_q, txn_d;

  // Flags come from registered pointers only, so a full FIFO refuses a push even while popping.
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int i = 0; i < N_CH; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      push[i]  = bus.req_valid[i] && !full[i];
    end
  end

  // rr_q is the first channel to search; the nearest non-empty channel from it wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    best_dist = N_CH;
    for (int c = 0; c < N_CH; c++) begin
      if (!empty[c] && (((c - int'(rr_q)) + N_CH) % N_CH) < best_dist) begin
        best_dist = ((c - int'(rr_q)) + N_CH) % N_CH;
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (enable_i && gnt_found) state_d = ST_HOLD;
      ST_HOLD:  if (bus.out_ready && !(enable_i && gnt_found)) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_HOLD);
    accept    = out_valid && bus.out_ready;
    load      = enable_i && gnt_found && (!out_valid || bus.out_ready);
    pop       = '0;
    if (load) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d       = rr_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    txn_d      = txn_q;
    for (int i = 0; i < N_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      ch_cnt_d[i] = ch_cnt_q[i];
    end
    if (accept) begin
      txn_d              = txn_q + 32'd1;
      ch_cnt_d[out_ch_q] = ch_cnt_q[out_ch_q] + CNT_W'(1);
    end
    if (load) begin
      out_data_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];
      out_ch_d   = gnt_idx;
      rr_d       = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        ch_cnt_q[i] <= '0;
      end
      rr_q       <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      txn_q      <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        ch_cnt_q[i] <= ch_cnt_d[i];
      end
      rr_q       <= rr_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      txn_q      <= txn_d;
    end
  end

  // Storage needs no reset: pointers alone decide what is valid.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.req_ready = ~full;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign txn_count_o   = txn_q;
  assign idle_o        = (&empty) && !out_valid;

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign ch_count_o[g*CNT_W +: CNT_W] = ch_cnt_q[g];
  end
endmodule

// File: tb/tb_smoke_mc_bfm.sv
// tb/tb_smoke_mc_bfm.sv - randomized and directed checks of smoke_mc_bfm against a queue-based model
module tb_smoke_mc_bfm;
  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   enable = 1'b0;
  logic [N_CH*CNT_W-1:0]  ch_count;
  logic [31:0]            txn_count;
  logic                   idle;

  smoke_mc_bfm_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  smoke_mc_bfm #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .enable_i    (enable),
    .bus         (bus),
    .ch_count_o  (ch_count),
    .txn_count_o (txn_count),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: one queue per channel plus a single held output slot.
  logic [DATA_W-1:0] mq [N_CH][$];
  bit                m_valid = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_ch = 0;
  int                m_rr = 0;
  int                m_cnt [N_CH];
  int                m_txn = 0;
  bit                was_full [N_CH];
  bit                found;
  int                cand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        mq[i].delete();
        m_cnt[i] = 0;
      end
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_rr    = 0;
      m_txn   = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) was_full[i] = (mq[i].size() >= DEPTH);
      if (m_valid && bus.out_ready) begin
        m_cnt[m_ch]++;
        m_txn++;
        m_valid = 1'b0;
      end
      if (enable && !m_valid) begin
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
          cand = (m_rr + k) % N_CH;
          if (!found && mq[cand].size() > 0) begin
            found   = 1'b1;
            m_data  = mq[cand].pop_front();
            m_ch    = cand;
            m_valid = 1'b1;
            m_rr    = (cand + 1) % N_CH;
          end
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (bus.req_valid[i] && !was_full[i]) mq[i].push_back(bus.req_data[i*DATA_W +: DATA_W]);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(m_data));
      chk("out_ch", 64'(bus.out_ch), 64'(m_ch));
    end
    for (int i = 0; i < N_CH; i++) begin
      chk("req_ready", 64'(bus.req_ready[i]), 64'(mq[i].size() < DEPTH));
      chk("ch_count", 64'(ch_count[i*CNT_W +: CNT_W]), 64'(m_cnt[i][CNT_W-1:0]));
    end
    chk("idle", 64'(idle), 64'((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() == 0) && !m_valid));
    chk("txn_count", 64'(txn_count), 64'(m_txn));
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int got;
  int cycles;
  int pushes;
  bit will;
  int stale;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // Reset with every channel requesting
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    step(3);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'hF);
    chk("rst_txn", 64'(txn_count), 64'd0);
    chk("rst_ch_count", 64'(ch_count), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    bus.req_valid = '0;
    rst_n = 1'b1;
    step(1);

    // Single push on channel 2
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data[2*DATA_W +: DATA_W] = 32'hA5A5_0002;
    step(1);
    bus.req_valid = '0;
    chk("single_no_bypass", 64'(bus.out_valid), 64'd0);
    step(1);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_ch", 64'(bus.out_ch), 64'd2);
    chk("single_data", 64'(bus.out_data), 64'hA5A5_0002);
    step(1);
    chk("single_ch2_count", 64'(ch_count[2*CNT_W +: CNT_W]), 64'd1);
    chk("single_txn", 64'(txn_count), 64'd1);
    chk("single_idle", 64'(idle), 64'd1);

    // Round-robin over preloaded channels
    do_reset();
    enable        = 1'b0;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < N_CH; i++) bus.req_data[i*DATA_W +: DATA_W] = 32'h3000_0000 | (i << 8) | w;
      step(1);
    end
    bus.req_valid = '0;
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    got    = 0;
    cycles = 0;
    while (got < 8 && cycles < 12) begin
      step(1);
      cycles++;
      if (bus.out_valid) begin
        chk("rr_order", 64'(bus.out_ch), 64'(got % N_CH));
        got++;
      end
    end
    chk("rr_count", 64'(got), 64'd8);
    chk("rr_cycles", 64'(cycles), 64'd8);

    // Backpressure: fill channel 1 to DEPTH plus the output stage
    do_reset();
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    pushes = 0;
    for (int a = 0; a < 7; a++) begin
      bus.req_data[1*DATA_W +: DATA_W] = 32'h4000_0000 + pushes;
      will = bus.req_ready[1];
      step(1);
      if (will) pushes++;
    end
    bus.req_valid = '0;
    chk("full_pushes", 64'(pushes), 64'd5);
    chk("full_ready", 64'(bus.req_ready[1]), 64'd0);
    for (int s = 0; s < 10; s++) begin
      step(1);
      chk("stall_data", 64'(bus.out_data), 64'h4000_0000);
    end

    // enable=0: held word still drains, nothing new loads
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    chk("hold_drained", 64'(bus.out_valid), 64'd0);
    step(3);
    chk("hold_no_load", 64'(bus.out_valid), 64'd0);
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    got    = 0;
    cycles = 0;
    while (got < 4 && cycles < 10) begin
      step(1);
      cycles++;
      if (bus.out_valid) begin
        chk("resume_order", 64'(bus.out_data), 64'(32'h4000_0001 + got));
        got++;
      end
    end
    chk("resume_count", 64'(got), 64'd4);

    // Reset in the middle of a burst
    do_reset();
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int s = 0; s < 3; s++) begin
      bus.req_data = {$urandom, $urandom, $urandom, $urandom};
      step(1);
    end
    chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    bus.req_valid = '0;
    step(2);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int s = 0; s < 8; s++) begin
      step(1);
      if (bus.out_valid) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);

    // Random traffic
    do_reset();
    for (int r = 0; r < 800; r++) begin
      bus.req_valid = N_CH'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      enable        = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step(1);
    end
    bus.req_valid = '0;
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    step(24);
    chk("final_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
